// File: rtl/register32b_pkg.sv
// Shared types and helpers for the register32b load/unload path.
// The future deserializer reuses the same state names and counter-width helper.
package register32b_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2, used to size counters that must hold the value WIDTH itself.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/register32b_serializer_bit_down_counter.sv
// Loadable down counter with an advance enable and a "last" (count == 1) flag.
// It saturates at zero, so a spurious enable after the final bit does not wrap.
module bit_down_counter
    import register32b_pkg::*;
#(
    parameter int MAX_COUNT = WIDTH_DEFAULT
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              load,
    input  logic                              en,
    input  logic [clog2(MAX_COUNT + 1)-1:0]   load_value,
    output logic [clog2(MAX_COUNT + 1)-1:0]   count,
    output logic                              last
);

    localparam int CW = clog2(MAX_COUNT + 1);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/register32b_serializer.sv
// Parallel-in / serial-out unload stage: captures a word on Load and presents
// one bit per En-qualified cycle, pulsing Done for one cycle after the last bit.
module register32b_serializer
    import register32b_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Load,
    input  logic                          En,
    input  logic [WIDTH-1:0]              Data_in,
    output logic                          Serial_out,
    output logic                          Bit_valid,
    output logic                          Busy,
    output logic                          Done,
    output logic [clog2(WIDTH + 1)-1:0]   Bits_left
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic             accept;
    logic             advance;
    logic             cnt_last;

    // A new word is accepted from IDLE or straight out of DONE (no idle bubble).
    assign accept  = Load && (state != SHIFT);
    assign advance = (state == SHIFT) && En;

    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    bit_down_counter #(
        .MAX_COUNT (WIDTH)
    ) u_bit_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (accept),
        .en         (advance),
        .load_value (CW'(WIDTH)),
        .count      (Bits_left),
        .last       (cnt_last)
    );

    // NOTE: the data register is reset as well, so an aborted word can never
    // reappear on Serial_out after Reset is released.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        shreg <= Data_in;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (En) begin
                        shreg <= shreg_shifted;
                        if (cnt_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (Load) begin
                        shreg <= Data_in;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; only Bit_valid follows En directly.
    assign Busy       = (state == SHIFT);
    assign Done       = (state == DONE);
    assign Bit_valid  = advance;
    assign Serial_out = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule
